// File: rtl/lcb_responder_if.sv
// rtl/lcb_responder_if.sv - LCB line and response-memory signals of lcb_responder
interface lcb_responder_if;
   logic        RX;
   logic        TX;
   logic        dirTX;
   logic        dirRX;
   logic [10:0] oRdAddr;
   logic        oRdEn;
   logic [7:0]  iData;

   // responder side: drives the line and the memory read port
   modport master (
      input  RX,
      input  iData,
      output TX,
      output dirTX,
      output dirRX,
      output oRdAddr,
      output oRdEn
   );

   // environment side: line partner and response memory
   modport slave (
      output RX,
      output iData,
      input  TX,
      input  dirTX,
      input  dirRX,
      input  oRdAddr,
      input  oRdEn
   );
endinterface

// File: rtl/lcb_responder.sv
// rtl/lcb_responder.sv - LCB far-end responder: 8N1 request in, memory-sourced response out
module lcb_responder #(
   parameter int CLKS_PER_BIT = 80,
   parameter int REQ_BYTES    = 14,
   parameter int RESP_BYTES   = 16,
   parameter int GAP_CLKS     = 400,
   parameter int TURN_CLKS    = 160
) (
   input  logic           clk,
   input  logic           reset,
   lcb_responder_if.master lcb,
   output logic [4:0]     oCycle,
   output logic [15:0]    oFrameCnt,
   output logic [7:0]     oErrCnt,
   output logic           oBusy
);

   localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
   // next-byte read issued so iData is valid on the last stop-bit clock
   localparam logic [15:0] FETCH_AT  = 16'(CLKS_PER_BIT - 4);
   localparam logic [15:0] GAP_LAST  = 16'(GAP_CLKS - 1);
   // TURN is shortened by 2 so the first fetch/load adds exactly 2 clocks
   localparam logic [15:0] TURN_LAST = 16'(TURN_CLKS - 3);
   localparam logic [7:0]  REQ_LAST  = 8'(REQ_BYTES - 1);
   localparam logic [6:0]  RESP_LAST = 7'(RESP_BYTES - 1);

   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
   typedef enum logic [3:0] {T_IDLE, T_TURN, T_FETCH, T_WAIT2, T_LOAD,
                             T_START, T_DATA, T_STOP, T_DONE} tx_state_t;

   rx_state_t   rx_state;
   tx_state_t   tx_state;
   logic        rx_s1, rx_s2, rx_s3;
   logic [15:0] rx_cnt, gap_cnt, tx_cnt;
   logic [2:0]  rx_bit, tx_bit;
   logic [7:0]  rx_shift, byte_cnt, byte0, tx_shift;
   logic [6:0]  idx;
   logic        tx_q, dir_tx_q, dir_rx_q, rd_en_q;
   logic [10:0] rd_addr_q;

   logic       stop_sample, frame_err, gap_err, frame_done, cyc_ok, accept, drop;
   logic [7:0] byte0_eff;

   assign stop_sample = (rx_state == R_STOP) && (rx_cnt == BIT_LAST);
   assign frame_err   = stop_sample && !rx_s2;
   assign gap_err     = (rx_state == R_IDLE) && (byte_cnt != 8'd0) && (gap_cnt == GAP_LAST);
   assign frame_done  = stop_sample && rx_s2 && (byte_cnt == REQ_LAST);
   assign byte0_eff   = (byte_cnt == 8'd0) ? rx_shift : byte0;
   assign cyc_ok      = (byte0_eff >= 8'd1) && (byte0_eff <= 8'd32);
   assign accept      = frame_done && cyc_ok;
   assign drop        = frame_err || gap_err || (frame_done && !cyc_ok);

   assign lcb.TX      = tx_q;
   assign lcb.dirTX   = dir_tx_q;
   assign lcb.dirRX   = dir_rx_q;
   assign lcb.oRdEn   = rd_en_q;
   assign lcb.oRdAddr = rd_addr_q;

   // double-synchronise RX, third stage gives the falling-edge reference
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
         rx_s3 <= 1'b1;
      end else begin
         rx_s1 <= lcb.RX;
         rx_s2 <= rx_s1;
         rx_s3 <= rx_s2;
      end
   end

   // 8N1 bit receiver; ignores the line entirely while a response is in progress
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_state <= R_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
      end else begin
         case (rx_state)
            R_IDLE: begin
               if (!oBusy && rx_s3 && !rx_s2) begin
                  rx_state <= R_START;
                  rx_cnt   <= '0;
               end
            end
            R_START: begin
               if (rx_cnt == HALF_LAST) begin
                  rx_cnt <= '0;
                  rx_bit <= '0;
                  rx_state <= rx_s2 ? R_IDLE : R_DATA;
               end else begin
                  rx_cnt <= rx_cnt + 16'd1;
               end
            end
            R_DATA: begin
               if (rx_cnt == BIT_LAST) begin
                  rx_cnt   <= '0;
                  rx_shift <= {rx_s2, rx_shift[7:1]};
                  rx_bit   <= rx_bit + 3'd1;
                  if (rx_bit == 3'd7) rx_state <= R_STOP;
               end else begin
                  rx_cnt <= rx_cnt + 16'd1;
               end
            end
            R_STOP: begin
               if (rx_cnt == BIT_LAST) rx_state <= R_IDLE;
               else                    rx_cnt   <= rx_cnt + 16'd1;
            end
            default: rx_state <= R_IDLE;
         endcase
      end
   end

   // frame assembly: byte count, inter-byte gap timeout, cycle check and counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         byte_cnt  <= '0;
         gap_cnt   <= '0;
         byte0     <= '0;
         oCycle    <= '0;
         oFrameCnt <= '0;
         oErrCnt   <= '0;
      end else begin
         if (stop_sample || byte_cnt == 8'd0) gap_cnt <= '0;
         else if (rx_state == R_IDLE)         gap_cnt <= gap_cnt + 16'd1;

         if (drop || frame_done)  byte_cnt <= '0;
         else if (stop_sample)    byte_cnt <= byte_cnt + 8'd1;

         if (stop_sample && rx_s2 && byte_cnt == 8'd0) byte0 <= rx_shift;

         if (drop && oErrCnt != 8'hFF) oErrCnt <= oErrCnt + 8'd1;

         if (accept) begin
            oFrameCnt <= oFrameCnt + 16'd1;
            oCycle    <= 5'(byte0_eff - 8'd1);
         end
      end
   end

   // response transmitter; later bytes are fetched inside the previous stop bit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_state  <= T_IDLE;
         tx_cnt    <= '0;
         tx_bit    <= '0;
         tx_shift  <= '0;
         idx       <= '0;
         tx_q      <= 1'b1;
         dir_tx_q  <= 1'b0;
         dir_rx_q  <= 1'b1;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         oBusy     <= 1'b0;
      end else begin
         rd_en_q <= 1'b0;
         case (tx_state)
            T_IDLE: begin
               if (accept) begin
                  tx_state <= T_TURN;
                  tx_cnt   <= '0;
                  idx      <= '0;
                  oBusy    <= 1'b1;
                  dir_tx_q <= 1'b1;
                  dir_rx_q <= 1'b0;
               end
            end
            T_TURN: begin
               if (tx_cnt == TURN_LAST) begin
                  tx_state  <= T_FETCH;
                  rd_en_q   <= 1'b1;
                  rd_addr_q <= {oCycle, 6'd0};
               end else begin
                  tx_cnt <= tx_cnt + 16'd1;
               end
            end
            T_FETCH: begin
               tx_state <= T_WAIT2;
               tx_cnt   <= '0;
            end
            T_WAIT2: begin
               if (tx_cnt == 16'd1) begin
                  tx_shift <= lcb.iData;
                  tx_state <= T_LOAD;
               end else begin
                  tx_cnt <= tx_cnt + 16'd1;
               end
            end
            T_LOAD: begin
               tx_state <= T_START;
               tx_cnt   <= '0;
               tx_q     <= 1'b0;
            end
            T_START: begin
               if (tx_cnt == BIT_LAST) begin
                  tx_state <= T_DATA;
                  tx_cnt   <= '0;
                  tx_bit   <= '0;
                  tx_q     <= tx_shift[0];
                  tx_shift <= {1'b0, tx_shift[7:1]};
               end else begin
                  tx_cnt <= tx_cnt + 16'd1;
               end
            end
            T_DATA: begin
               if (tx_cnt == BIT_LAST) begin
                  tx_cnt <= '0;
                  if (tx_bit == 3'd7) begin
                     tx_state <= T_STOP;
                     tx_q     <= 1'b1;
                  end else begin
                     tx_bit   <= tx_bit + 3'd1;
                     tx_q     <= tx_shift[0];
                     tx_shift <= {1'b0, tx_shift[7:1]};
                  end
               end else begin
                  tx_cnt <= tx_cnt + 16'd1;
               end
            end
            T_STOP: begin
               if (tx_cnt == FETCH_AT && idx != RESP_LAST) begin
                  rd_en_q   <= 1'b1;
                  rd_addr_q <= {oCycle, 6'(idx + 7'd1)};
               end
               if (tx_cnt == BIT_LAST) begin
                  tx_cnt <= '0;
                  idx    <= idx + 7'd1;
                  if (idx == RESP_LAST) begin
                     tx_state <= T_DONE;
                     dir_tx_q <= 1'b0;
                     dir_rx_q <= 1'b1;
                     oBusy    <= 1'b0;
                  end else begin
                     tx_state <= T_START;
                     tx_shift <= lcb.iData;
                     tx_q     <= 1'b0;
                  end
               end else begin
                  tx_cnt <= tx_cnt + 16'd1;
               end
            end
            T_DONE:  tx_state <= T_IDLE;
            default: tx_state <= T_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lcb_responder.sv
// tb/tb_lcb_responder.sv - scoreboard bench for lcb_responder
module tb_lcb_responder;
   localparam int CPB  = 16;
   localparam int REQ  = 14;
   localparam int RESP = 16;
   localparam int GAP  = 400;
   localparam int TURN = 160;
   localparam int RESP_TIME = TURN + 2 + RESP * 10 * CPB;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  oCycle;
   logic [15:0] oFrameCnt;
   logic [7:0]  oErrCnt;
   logic        oBusy;

   lcb_responder_if lcb_if ();

   lcb_responder #(
      .CLKS_PER_BIT(CPB), .REQ_BYTES(REQ), .RESP_BYTES(RESP),
      .GAP_CLKS(GAP), .TURN_CLKS(TURN)
   ) dut (
      .clk(clk), .reset(reset), .lcb(lcb_if),
      .oCycle(oCycle), .oFrameCnt(oFrameCnt), .oErrCnt(oErrCnt), .oBusy(oBusy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   logic [10:0] exp_addr[$];
   logic [7:0]  exp_byte[$];
   int exp_frames = 0;
   int exp_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // response memory: data = address low byte, valid 2 clks after the read strobe
   logic        en_d1 = 1'b0;
   logic [10:0] a_d1 = '0;
   always @(posedge clk) begin
      en_d1 <= lcb_if.oRdEn;
      a_d1  <= lcb_if.oRdAddr;
      if (en_d1) lcb_if.iData <= a_d1[7:0];
   end

   // busy/TX timing observer
   int cyc = 0, rise_cyc = 0, fall_cyc = 0, txfall_cyc = 0, n_rises = 0;
   logic busy_q = 1'b0;
   logic tx_seen = 1'b0;
   always @(negedge clk) begin
      cyc++;
      if (oBusy === 1'b1 && !busy_q) begin
         rise_cyc = cyc;
         tx_seen = 1'b0;
         n_rises++;
      end
      if (oBusy === 1'b0 && busy_q) fall_cyc = cyc;
      if (oBusy === 1'b1 && !tx_seen && lcb_if.TX === 1'b0) begin
         tx_seen = 1'b1;
         txfall_cyc = cyc;
      end
      busy_q = (oBusy === 1'b1);
   end

   // read-address scoreboard
   always @(negedge clk) begin
      if (lcb_if.oRdEn === 1'b1) begin
         check("rd_expected", (exp_addr.size() != 0), 1);
         if (exp_addr.size() != 0) check("rd_addr", lcb_if.oRdAddr, exp_addr.pop_front());
      end
   end

   // TX byte decoder and scoreboard; a reset during a byte discards it
   initial begin : tx_mon
      logic [7:0] b;
      logic stop_v;
      bit ok;
      forever begin
         @(negedge clk);
         if (reset === 1'b0 && lcb_if.TX === 1'b0) begin
            ok = 1;
            repeat (CPB / 2) begin @(negedge clk); if (reset) ok = 0; end
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) begin @(negedge clk); if (reset) ok = 0; end
               b[i] = lcb_if.TX;
            end
            repeat (CPB) begin @(negedge clk); if (reset) ok = 0; end
            stop_v = lcb_if.TX;
            if (ok) begin
               check("tx_expected", (exp_byte.size() != 0), 1);
               if (exp_byte.size() != 0) check("tx_byte", b, exp_byte.pop_front());
               check("tx_stop", stop_v, 1);
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      lcb_if.RX = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         lcb_if.RX = b[i];
         repeat (CPB) @(negedge clk);
      end
      lcb_if.RX = stop_bit;
      repeat (CPB) @(negedge clk);
      lcb_if.RX = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b0, input int nbytes);
      send_byte(b0, 1'b1);
      for (int i = 1; i < nbytes; i++) send_byte(8'(8'hA0 + i), 1'b1);
   endtask

   task automatic expect_resp(input logic [4:0] c);
      logic [10:0] a;
      for (int i = 0; i < RESP; i++) begin
         a = {c, 6'(i)};
         exp_addr.push_back(a);
         exp_byte.push_back(a[7:0]);
      end
   endtask

   task automatic wait_rise(input string tag);
      for (int i = 0; i < 200 && oBusy !== 1'b1; i++) @(negedge clk);
      check({tag, "_busy_rise"}, oBusy, 1);
   endtask

   task automatic run_response(input string tag, input logic [4:0] c);
      wait_rise(tag);
      check({tag, "_cycle"}, oCycle, c);
      check({tag, "_frames"}, oFrameCnt, exp_frames);
      check({tag, "_dirtx"}, {lcb_if.dirTX, lcb_if.dirRX}, 2'b10);
      for (int i = 0; i < RESP_TIME + 200 && oBusy !== 1'b0; i++) @(negedge clk);
      check({tag, "_busy_fall"}, oBusy, 0);
      repeat (4) @(negedge clk);
      check({tag, "_turn"}, txfall_cyc - rise_cyc, TURN + 2);
      check({tag, "_busy_len"}, fall_cyc - rise_cyc, RESP_TIME);
      check({tag, "_addr_left"}, exp_addr.size(), 0);
      check({tag, "_byte_left"}, exp_byte.size(), 0);
      check({tag, "_idle_line"}, {lcb_if.TX, lcb_if.dirTX, lcb_if.dirRX}, 3'b101);
      check({tag, "_errs"}, oErrCnt, exp_err);
   endtask

   task automatic no_response(input string tag, input int rises_before);
      repeat (200) @(negedge clk);
      check({tag, "_errs"}, oErrCnt, exp_err);
      check({tag, "_frames"}, oFrameCnt, exp_frames);
      check({tag, "_no_busy"}, n_rises, rises_before);
   endtask

   initial begin : watchdog
      #3ms;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin : main
      int r;
      reset = 1'b1;
      lcb_if.RX = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_tx", lcb_if.TX, 1);
      check("rst_dirtx", lcb_if.dirTX, 0);
      check("rst_dirrx", lcb_if.dirRX, 1);
      check("rst_rden", lcb_if.oRdEn, 0);
      check("rst_rdaddr", lcb_if.oRdAddr, 0);
      check("rst_cycle", oCycle, 0);
      check("rst_frames", oFrameCnt, 0);
      check("rst_errs", oErrCnt, 0);
      check("rst_busy", oBusy, 0);
      reset = 1'b0;
      repeat (10) @(negedge clk);

      // valid request, cycle byte 5
      expect_resp(5'd4); exp_frames++;
      send_frame(8'd5, REQ);
      run_response("valid", 5'd4);

      // framing error on byte 3, then a valid request
      r = n_rises;
      send_byte(8'd5, 1'b1); send_byte(8'hA1, 1'b1); send_byte(8'hA2, 1'b1);
      send_byte(8'hA3, 1'b0);
      exp_err++;
      repeat (GAP + 200) @(negedge clk);
      no_response("framing", r);
      expect_resp(5'd0); exp_frames++;
      send_frame(8'd1, REQ);
      run_response("after_framing", 5'd0);

      // gap timeout on a 6-byte partial frame, then cycle 32
      r = n_rises;
      send_frame(8'd7, 6);
      repeat (500) @(negedge clk);
      exp_err++;
      no_response("gap", r);
      expect_resp(5'd31); exp_frames++;
      send_frame(8'd32, REQ);
      run_response("after_gap", 5'd31);

      // out-of-range cycle bytes
      r = n_rises;
      send_frame(8'd0, REQ); exp_err++;
      no_response("cycle0", r);
      send_frame(8'd33, REQ); exp_err++;
      no_response("cycle33", r);

      // echo pulses on RX while the response is on the line
      expect_resp(5'd8); exp_frames++;
      send_frame(8'd9, REQ);
      fork
         begin
            for (int p = 0; p < 20; p++) begin
               lcb_if.RX = 1'b0; repeat (10) @(negedge clk);
               lcb_if.RX = 1'b1; repeat (90) @(negedge clk);
            end
         end
      join_none
      run_response("echo", 5'd8);

      // reset while byte 7 is in its data bits
      expect_resp(5'd2);
      send_frame(8'd3, REQ);
      wait_rise("rst_mid");
      repeat (TURN + 2 + 7 * 10 * CPB + 3 * CPB) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("rst_mid_tx", lcb_if.TX, 1);
      check("rst_mid_dirtx", lcb_if.dirTX, 0);
      check("rst_mid_frames", oFrameCnt, 0);
      check("rst_mid_errs", oErrCnt, 0);
      check("rst_mid_busy", oBusy, 0);
      exp_addr.delete();
      exp_byte.delete();
      exp_frames = 0;
      exp_err = 0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (10 * CPB) @(negedge clk);
      expect_resp(5'd4); exp_frames++;
      send_frame(8'd5, REQ);
      run_response("after_reset", 5'd4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
